reg16_byte_unloader: RTL and testbench

Reads a captured 16-bit word out onto the CPU's 8-bit data bus as two sequential bytes with a valid/ready handshake. It is the read-side counterpart of the CPU's 16-bit load registers. It is used wherever a 16-bit value (PC, address pointer, stack pointer) must leave the core over the 8-bit bus, e.g. pushing the return address during CALL. Byte order is selectable per transfer.

---
 rtl/reg16_byte_unloader_pkg.sv | 16 +
 rtl/reg16_byte_unloader_word_shadow.sv | 25 ++
 rtl/reg16_byte_unloader.sv | 101 ++++++++++
 tb/tb_reg16_byte_unloader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/reg16_byte_unloader_pkg.sv
// Shared definitions for the 16-bit word unloader and its bus-side loader twin.
// Holds state encoding, default bus width and byte-order constants.
package reg16_byte_unloader_pkg;

  localparam int BUS_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BYTE0 = 2'b01,
    BYTE1 = 2'b10
  } state_e;

  localparam logic ORDER_LO_FIRST = 1'b0;
  localparam logic ORDER_HI_FIRST = 1'b1;

endpackage

// File: rtl/reg16_byte_unloader_word_shadow.sv
// Capture register holding the word for the duration of a transfer.
// Loads on enable, clears asynchronously on reset.
module reg16_byte_unloader_word_shadow #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] word_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
    end else if (load_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg16_byte_unloader.sv
// Unloads a captured 2*BUS_W word onto the byte bus as two handshaked bytes.
// Outputs decode only registered state, so none depends on start or ready.
module reg16_byte_unloader
  import reg16_byte_unloader_pkg::*;
#(
  parameter int BUS_W = BUS_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [2*BUS_W-1:0] in_i,
  input  logic               start_i,
  input  logic               hi_first_i,
  output logic [BUS_W-1:0]   bus_out_o,
  output logic               bus_valid_o,
  input  logic               bus_ready_i,
  output logic               busy_o,
  output logic               done_o
);

  state_e             state_q, state_d;
  logic               order_q, order_d;
  logic               done_q, done_d;
  logic               load;
  logic [2*BUS_W-1:0] shadow;
  logic [BUS_W-1:0]   byte_hi, byte_lo;

  reg16_byte_unloader_word_shadow #(
    .W(2*BUS_W)
  ) u_shadow (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .d_i    (in_i),
    .q_o    (shadow)
  );

  assign byte_hi = shadow[2*BUS_W-1:BUS_W];
  assign byte_lo = shadow[BUS_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      order_q <= ORDER_LO_FIRST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    order_d = order_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          order_d = hi_first_i;
          state_d = BYTE0;
        end
      end
      BYTE0: begin
        if (bus_ready_i) begin
          state_d = BYTE1;
        end
      end
      BYTE1: begin
        if (bus_ready_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_out_o   = '0;
    bus_valid_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      BYTE0: begin
        bus_valid_o = 1'b1;
        busy_o      = 1'b1;
        bus_out_o   = (order_q == ORDER_HI_FIRST) ? byte_hi : byte_lo;
      end
      BYTE1: begin
        bus_valid_o = 1'b1;
        busy_o      = 1'b1;
        bus_out_o   = (order_q == ORDER_HI_FIRST) ? byte_lo : byte_hi;
      end
      default: ;
    endcase
  end

  assign done_o = done_q;

endmodule

// File: tb/tb_reg16_byte_unloader.sv
// Bench for reg16_byte_unloader: directed cases plus a byte scoreboard.
module tb_reg16_byte_unloader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_w;
  logic        start;
  logic        hi_first;
  logic [7:0]  bus_out;
  logic        bus_valid;
  logic        bus_ready;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  int         m_state = 0;
  logic       m_done = 1'b0;

  always #5 clk = ~clk;

  reg16_byte_unloader #(.BUS_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_i        (in_w),
    .start_i     (start),
    .hi_first_i  (hi_first),
    .bus_out_o   (bus_out),
    .bus_valid_o (bus_valid),
    .bus_ready_i (bus_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Spec model: checks at negedge, then predicts the state after the next edge.
  always @(negedge clk) begin
    logic [7:0] e;
    chk("valid", {31'b0, bus_valid}, {31'b0, m_state != 0});
    chk("busy", {31'b0, busy}, {31'b0, m_state != 0});
    chk("done", {31'b0, done}, {31'b0, m_done});
    if (m_state == 0) chk("idle_out", {24'b0, bus_out}, 32'h0);
    m_done = 1'b0;
    if (!rst) begin
      case (m_state)
        0: if (start) begin
          sb_q.push_back(hi_first ? in_w[15:8] : in_w[7:0]);
          sb_q.push_back(hi_first ? in_w[7:0] : in_w[15:8]);
          m_state = 1;
        end
        1, 2: if (bus_ready) begin
          chk("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'h1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_byte", {24'b0, bus_out}, {24'b0, e});
          end
          if (m_state == 2) begin
            m_state = 0;
            m_done  = 1'b1;
          end else begin
            m_state = 2;
          end
        end
        default: m_state = 0;
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_w = '0;
    start = 1'b0;
    hi_first = 1'b0;
    bus_ready = 1'b0;
    #1;
    chk("rst_valid", {31'b0, bus_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_out", {24'b0, bus_out}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // low byte first, no stall
    in_w = 16'hA55A; hi_first = 1'b0; start = 1'b1; bus_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_b0", {24'b0, bus_out}, 32'h5A);
    chk("t1_v0", {31'b0, bus_valid}, 32'h1);
    tick();
    chk("t1_b1", {24'b0, bus_out}, 32'hA5);
    tick();
    chk("t1_done", {31'b0, done}, 32'h1);
    chk("t1_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("t1_done_off", {31'b0, done}, 32'h0);

    // high byte first with a four-cycle stall
    in_w = 16'h1234; hi_first = 1'b1; start = 1'b1; bus_ready = 1'b0;
    tick();
    start = 1'b0; in_w = 16'h0000; hi_first = 1'b0;
    repeat (4) begin
      chk("t2_stall", {24'b0, bus_out}, 32'h12);
      tick();
    end
    chk("t2_hold", {24'b0, bus_out}, 32'h12);
    bus_ready = 1'b1;
    tick();
    chk("t2_b1", {24'b0, bus_out}, 32'h34);
    tick();
    chk("t2_done", {31'b0, done}, 32'h1);
    tick();

    // new input and start while busy are ignored
    in_w = 16'hBEEF; hi_first = 1'b0; start = 1'b1;
    tick();
    in_w = 16'h0000;
    chk("t3_b0", {24'b0, bus_out}, 32'hEF);
    tick();
    chk("t3_b1", {24'b0, bus_out}, 32'hBE);
    start = 1'b0;
    tick();
    chk("t3_done", {31'b0, done}, 32'h1);
    tick();
    chk("t3_idle", {31'b0, busy}, 32'h0);

    // back-to-back with start held high
    in_w = 16'h0102; hi_first = 1'b0; start = 1'b1;
    tick();
    in_w = 16'h0304; hi_first = 1'b1;
    chk("t4_b0", {24'b0, bus_out}, 32'h02);
    tick();
    chk("t4_b1", {24'b0, bus_out}, 32'h01);
    tick();
    chk("t4_done1", {31'b0, done}, 32'h1);
    tick();
    start = 1'b0;
    chk("t4_b2", {24'b0, bus_out}, 32'h03);
    tick();
    chk("t4_b3", {24'b0, bus_out}, 32'h04);
    tick();
    chk("t4_done2", {31'b0, done}, 32'h1);
    tick();

    // reset while stalled in the second byte
    in_w = 16'hCAFE; hi_first = 1'b0; start = 1'b1; bus_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus_ready = 1'b0;
    tick();
    chk("t5_pre", {24'b0, bus_out}, 32'hCA);
    #1;
    rst = 1'b1;
    m_state = 0;
    m_done = 1'b0;
    sb_q.delete();
    #1;
    chk("t5_valid", {31'b0, bus_valid}, 32'h0);
    chk("t5_busy", {31'b0, busy}, 32'h0);
    chk("t5_out", {24'b0, bus_out}, 32'h0);
    tick();
    rst = 1'b0;
    chk("t5_nodone", {31'b0, done}, 32'h0);
    tick();
    in_w = 16'h00FF; hi_first = 1'b0; start = 1'b1; bus_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_b0", {24'b0, bus_out}, 32'hFF);
    tick();
    chk("t5_b1", {24'b0, bus_out}, 32'h00);
    tick();
    chk("t5_done", {31'b0, done}, 32'h1);
    tick();
    tick();

    chk("sb_empty", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
